// File: rtl/mont_pkg.sv
// mont_pkg: shared definitions for the Montgomery-domain encoder.
// Holds the default modulus/width, the controller state encoding and the
// two's-complement negation of the default modulus.
// No ports.
package mont_pkg;

   localparam int DEF_K    = 192;
   localparam int DEF_LOGK = 8;
   localparam logic [DEF_K-1:0] DEF_M =
      192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

   // -m in k+2 bits: adding this to a doubled operand gives the trial subtraction
   localparam logic [DEF_K+1:0] DEF_MINUS_M = -{2'b00, DEF_M};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DONE  = 3'd3
   } state_t;

endpackage

// File: rtl/mod_dbl.sv
// mod_dbl: combinational modular doubling, o_p = 2*i_p mod M.
// Requires 0 <= i_p < M; the result then also satisfies 0 <= o_p < M.
// Ports:
//   i_p  [K:0]  operand (top bit is zero whenever the precondition holds)
//   o_p  [K:0]  2*i_p mod M
module mod_dbl
   import mont_pkg::*;
#(
   parameter int         K = DEF_K,
   parameter logic [K-1:0] M = DEF_M
) (
   input  logic [K:0] i_p,
   output logic [K:0] o_p
);

   localparam logic [K+1:0] MINUS_M = -{2'b00, M};

   logic [K+1:0] w_t;

   // 2p - m in k+2 bits; bit K+1 is the sign since |2p - m| < 2^(k+1)
   assign w_t = {i_p, 1'b0} + MINUS_M;
   assign o_p = w_t[K+1] ? {i_p[K-1:0], 1'b0} : w_t[K:0];

endmodule

// File: rtl/mont_encode.sv
// mont_encode: converts x into the Montgomery domain, z = x*2^K mod M,
// one modular doubling per cycle (K doublings per conversion).
// Optional feature macro: MONT_ENC_REDUCE_IN_EN -- when defined, the loaded
// operand is reduced once (x - M if x >= M) so any K-bit x is accepted.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_start  level request, held until o_done is seen
//   i_x      [K-1:0] operand, captured on the accepting edge
//   o_z      [K-1:0] result, registered, valid while o_done is high
//   o_done   result valid, held until i_start drops
//
// state | meaning
// IDLE  | waiting for i_start; captures i_x when it is seen
// LOAD  | loads p from the captured operand, clears the counter
// SHIFT | one modular doubling per cycle, K cycles
// DONE  | o_done high, o_z stable until i_start drops
module mont_encode
   import mont_pkg::*;
#(
   parameter int         K    = DEF_K,
   parameter int         LOGK = DEF_LOGK,
   parameter logic [K-1:0] M  = DEF_M
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [K-1:0] i_x,
   output logic [K-1:0] o_z,
   output logic         o_done
);

   localparam logic [LOGK-1:0] LAST_CNT = LOGK'(K-1);

   state_t          r_state;
   state_t          w_next;
   logic [K-1:0]    r_x;
   logic [K-1:0]    r_z;
   logic [K:0]      r_p;
   logic [K:0]      w_p_dbl;
   logic [K:0]      w_p_init;
   logic [LOGK-1:0] r_count;
   logic            r_done;
   logic            w_last;

   mod_dbl #(.K(K), .M(M)) u_dbl (
      .i_p (r_p),
      .o_p (w_p_dbl)
   );

`ifdef MONT_ENC_REDUCE_IN_EN
   logic [K:0] w_x_sub;
   assign w_x_sub  = {1'b0, r_x} - {1'b0, M};
   assign w_p_init = w_x_sub[K] ? {1'b0, r_x} : w_x_sub;
`else
   assign w_p_init = {1'b0, r_x};
`endif

   assign w_last = (r_count == LAST_CNT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_SHIFT;
         ST_SHIFT: if (w_last) w_next = ST_DONE;
         ST_DONE:  if (!i_start) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x     <= '0;
         r_p     <= '0;
         r_count <= '0;
         r_z     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (w_next == ST_DONE);
         case (r_state)
            ST_IDLE: if (i_start) r_x <= i_x;
            ST_LOAD: begin
               r_p     <= w_p_init;
               r_count <= '0;
            end
            ST_SHIFT: begin
               r_p     <= w_p_dbl;
               r_count <= r_count + LOGK'(1);
               // result register is written once, on the final doubling
               if (w_last) r_z <= w_p_dbl[K-1:0];
            end
            default: ;
         endcase
      end
   end

   assign o_z    = r_z;
   assign o_done = r_done;

endmodule

// File: tb/tb_mont_encode.sv
module tb_mont_encode;
   import mont_pkg::*;

   typedef struct {
      logic [7:0] x;
      logic [7:0] z;
   } vec8_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst8, start8, done8;
   logic [7:0]   x8, z8;
   logic         rst_d, start_d, done_d;
   logic [191:0] x_d, z_d;

   int checks   = 0;
   int failures = 0;

   mont_encode #(.K(8), .LOGK(4), .M(8'd241)) u_dut8 (
      .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_x(x8), .o_z(z8), .o_done(done8)
   );

   mont_encode u_dut192 (
      .i_clk(clk), .i_rst(rst_d), .i_start(start_d), .i_x(x_d), .o_z(z_d), .o_done(done_d)
   );

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // x*2^kk mod mm straight from the definition
   function automatic logic [191:0] ref_enc(input logic [191:0] xv, input int kk,
                                            input logic [191:0] mm);
      logic [383:0] num;
      logic [383:0] rem;
      num = {192'b0, xv} << kk;
      rem = num % {192'b0, mm};
      return rem[191:0];
   endfunction

   // mod_mul(z, 1) = z * 2^-kk mod mm, by halving modulo an odd modulus
   function automatic logic [191:0] ref_dec(input logic [191:0] zv, input int kk,
                                            input logic [191:0] mm);
      logic [193:0] a;
      a = {2'b00, zv};
      for (int i = 0; i < kk; i++) begin
         if (a[0]) a = a + {2'b00, mm};
         a = a >> 1;
      end
      return a[191:0];
   endfunction

   task automatic run8(input logic [7:0] xv, output logic [7:0] zv, output int lat);
      @(negedge clk);
      x8 = xv;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      x8 = ~xv;
      lat = 0;
      while (!done8 && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
      zv = z8;
   endtask

   task automatic run_d(input logic [191:0] xv, output logic [191:0] zv, output int lat);
      @(negedge clk);
      x_d = xv;
      start_d = 1'b1;
      @(posedge clk);
      #1;
      x_d = ~xv;
      lat = 0;
      while (!done_d && lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      zv = z_d;
   endtask

   task automatic release8();
      @(negedge clk);
      start8 = 1'b0;
      @(posedge clk);
      #1;
      chk("done8_drop", {191'b0, done8}, 192'd0);
   endtask

   task automatic release_d();
      @(negedge clk);
      start_d = 1'b0;
      @(posedge clk);
      #1;
      chk("done192_drop", {191'b0, done_d}, 192'd0);
   endtask

   function automatic logic [191:0] rand_below_m();
      logic [191:0] v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (v >= DEF_M) v = v - DEF_M;
      return v;
   endfunction

   initial begin
      vec8_t        tbl[$];
      logic [7:0]   zr8, zprev8;
      logic [191:0] zr, xr;
      int           lat;
      bit           seen;

      tbl.push_back('{x: 8'd1,   z: 8'd15});
      tbl.push_back('{x: 8'd100, z: 8'd54});
      tbl.push_back('{x: 8'd0,   z: 8'd0});
      tbl.push_back('{x: 8'd240, z: 8'd226});
      tbl.push_back('{x: 8'd120, z: 8'd113});
      tbl.push_back('{x: 8'd17,  z: 8'd14});
`ifdef MONT_ENC_REDUCE_IN_EN
      tbl.push_back('{x: 8'd250, z: 8'd135});
      tbl.push_back('{x: 8'd255, z: 8'd210});
`endif

      rst8 = 1'b1; start8 = 1'b0; x8 = '0;
      rst_d = 1'b1; start_d = 1'b0; x_d = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done8", {191'b0, done8}, 192'd0);
      chk("reset_z8", {184'b0, z8}, 192'd0);
      chk("reset_done192", {191'b0, done_d}, 192'd0);
      chk("reset_z192", z_d, 192'd0);
      @(negedge clk);
      rst8 = 1'b0;
      rst_d = 1'b0;

      foreach (tbl[i]) begin
         run8(tbl[i].x, zr8, lat);
         chk($sformatf("tbl8_z[%0d]", i), {184'b0, zr8}, {184'b0, tbl[i].z});
         chk($sformatf("tbl8_lat[%0d]", i), 192'(lat), 192'd9);
         release8();
      end

      // result and done must stay put while start is held past done
      run8(8'd100, zr8, lat);
      zprev8 = zr8;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         chk("hold_z8", {184'b0, z8}, {184'b0, zprev8});
         chk("hold_done8", {191'b0, done8}, 192'd1);
      end
      release8();

      for (int n = 0; n < 100; n++) begin
         logic [7:0] xv;
`ifdef MONT_ENC_REDUCE_IN_EN
         xv = 8'($urandom_range(255, 0));
`else
         xv = 8'($urandom_range(240, 0));
`endif
         run8(xv, zr8, lat);
         chk("rand8_z", {184'b0, zr8}, ref_enc({184'b0, xv}, 8, 192'd241));
         release8();
      end

      run_d(192'd1, zr, lat);
      chk("def_x1_z", zr, 192'h000000000000000000000000000000010000000000000001);
      chk("def_x1_lat", 192'(lat), 192'd193);
      release_d();

      // abort mid-conversion: z was nonzero beforehand, must read 0 after reset
      @(negedge clk);
      x_d = rand_below_m();
      start_d = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      rst_d = 1'b1;
      start_d = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_done", {191'b0, done_d}, 192'd0);
      chk("abort_z", z_d, 192'd0);
      @(negedge clk);
      rst_d = 1'b0;
      seen = 1'b0;
      repeat (250) begin
         @(posedge clk);
         #1;
         if (done_d) seen = 1'b1;
      end
      chk("abort_no_done", {191'b0, seen}, 192'd0);
      xr = rand_below_m();
      run_d(xr, zr, lat);
      chk("restart_z", zr, ref_enc(xr, 192, DEF_M));
      chk("restart_lat", 192'(lat), 192'd193);
      release_d();

      for (int n = 0; n < 150; n++) begin
         xr = rand_below_m();
         run_d(xr, zr, lat);
         chk("rt_enc", zr, ref_enc(xr, 192, DEF_M));
         chk("rt_dec", ref_dec(zr, 192, DEF_M), xr);
         release_d();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
